// File: rtl/sonar_pkg.sv
// Shared types and 50 MHz default timing constants for the sonar echo capture block.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } sonar_state_e;

  localparam int unsigned TRIG_CYCLES_50M    = 500;
  localparam int unsigned TIMEOUT_CYCLES_50M = 1900000;

endpackage

// File: rtl/pin_sync_filter.sv
// Two-flop synchronizer for the raw echo pin, with an optional FILT_N-sample
// glitch filter built when SONAR_FILTER_EN is defined.
module pin_sync_filter
`ifdef SONAR_FILTER_EN
#(
  parameter int unsigned FILT_N = 4
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic echo_s,
  output logic echo_s_d
);

  logic meta;
  logic sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

`ifdef SONAR_FILTER_EN
  localparam int unsigned RUN_W = $clog2(FILT_N + 1);

  logic [RUN_W-1:0] run;
  logic             filt;

  // run counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clock) begin
    if (reset) begin
      run  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      run <= '0;
    end else if (run == RUN_W'(FILT_N - 1)) begin
      filt <= sync;
      run  <= '0;
    end else begin
      run <= run + RUN_W'(1);
    end
  end

  assign echo_s = filt;
`else
  assign echo_s = sync;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      echo_s_d <= 1'b0;
    end else begin
      echo_s_d <= echo_s;
    end
  end

endmodule

// File: rtl/sonar_echo_capture.sv
// Sonar ping controller: drives the trigger pulse, times the echo high period.
// Build option SONAR_FILTER_EN adds an FILT_N-sample glitch filter on the echo.
module sonar_echo_capture
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_50M,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_50M,
  parameter int unsigned CNT_W          = 24
`ifdef SONAR_FILTER_EN
  ,
  parameter int unsigned FILT_N         = 4
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             echo_in,
  output logic             trig_out,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] width,
  output sonar_state_e     dbg_state
);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_MAX  = CNT_W'(TIMEOUT_CYCLES);

  sonar_state_e     state;
  sonar_state_e     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] width_next;
  logic             timeout_next;
  logic             echo_s;
  logic             echo_s_d;
  logic             rise;
  logic             fall;

  pin_sync_filter
`ifdef SONAR_FILTER_EN
  #(
    .FILT_N(FILT_N)
  )
`endif
  u_sync (
    .clock   (clock),
    .reset   (reset),
    .pin     (echo_in),
    .echo_s  (echo_s),
    .echo_s_d(echo_s_d)
  );

  assign rise      = echo_s & ~echo_s_d;
  assign fall      = ~echo_s & echo_s_d;
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      width   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      width   <= width_next;
      timeout <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    width_next   = width;
    timeout_next = timeout;
    trig_out     = 1'b0;
    busy         = 1'b0;
    valid        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = TRIG;
          cnt_next   = '0;
        end
      end
      TRIG: begin
        trig_out = 1'b1;
        busy     = 1'b1;
        if (cnt == TRIG_LAST) begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        busy = 1'b1;
        // The rise cycle itself is part of the echo high time, hence cnt=1.
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = CNT_W'(1);
        end else if (cnt == WAIT_LAST) begin
          state_next   = DONE;
          width_next   = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      MEASURE: begin
        busy = 1'b1;
        if (fall) begin
          state_next   = DONE;
          width_next   = cnt;
          timeout_next = 1'b0;
        end else if (cnt == MEAS_MAX) begin
          state_next   = DONE;
          width_next   = MEAS_MAX;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sonar_echo_capture.sv
// Self-checking bench for sonar_echo_capture: table of pings, hand-written
// corner sequences, and random pings checked against a pulse-level model.
module tb_sonar_echo_capture;
  import sonar_pkg::*;

  localparam int P_TRIG = 4;
  localparam int P_TMO  = 100;
  localparam int W      = 24;
`ifdef SONAR_FILTER_EN
  localparam int P_FILT   = 3;
  localparam int LAT      = 2 + P_FILT;
  localparam int MINLEN   = P_FILT;
  localparam int GLITCH_W = 12;
`else
  localparam int LAT      = 2;
  localparam int MINLEN   = 1;
  localparam int GLITCH_W = 1;
`endif

  logic         clock;
  logic         reset;
  logic         start;
  logic         echo_in;
  logic         trig_out;
  logic         busy;
  logic         valid;
  logic         timeout;
  logic [W-1:0] width;
  sonar_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

`ifdef SONAR_FILTER_EN
  sonar_echo_capture #(
    .TRIG_CYCLES(P_TRIG), .TIMEOUT_CYCLES(P_TMO), .CNT_W(W), .FILT_N(P_FILT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .valid(valid), .timeout(timeout),
    .width(width), .dbg_state(dbg_state)
  );
`else
  sonar_echo_capture #(
    .TRIG_CYCLES(P_TRIG), .TIMEOUT_CYCLES(P_TMO), .CNT_W(W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .valid(valid), .timeout(timeout),
    .width(width), .dbg_state(dbg_state)
  );
`endif

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pulse-level reference: pin pulses at cycle a (relative to the first cycle
  // after trig_out falls) of length l. The first pulse long enough to survive
  // filtering whose synchronized rise lands inside the wait window is timed.
  function automatic void model(input int a1, input int l1, input int a2, input int l2,
                                output int ew, output bit et, output int vc);
    bit found = 0;
    ew = 0;
    et = 1;
    vc = P_TMO;
    for (int i = 0; i < 2; i++) begin
      int a = (i == 0) ? a1 : a2;
      int l = (i == 0) ? l1 : l2;
      if (!found && l >= MINLEN && a + LAT <= P_TMO - 1) begin
        found = 1;
        if (l > P_TMO) begin
          ew = P_TMO;
          et = 1;
          vc = a + LAT + P_TMO + 1;
        end else begin
          ew = l;
          et = 0;
          vc = a + l + LAT + 1;
        end
      end
    end
  endfunction

  // One full ping: start, measure trigger, drive echo pulses, await result.
  task automatic ping(input int a1, input int l1, input int a2, input int l2,
                      input bit restart, input int exp_w, input bit exp_t, input int exp_vc);
    int n;
    int c;
    int vcyc;
    int extra;
    logic [W-1:0] got_w;
    logic got_t;
    exp_q.push_back(exp_w[W-1:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (trig_out && n < 50) begin
      n++;
      start = restart && (n == 2);
      tick();
    end
    start = 1'b0;
    chk("trig_len", n, P_TRIG);
    c = 0;
    vcyc = -1;
    got_w = '0;
    got_t = 1'b0;
    while (c < 400 && vcyc < 0) begin
      echo_in = (c >= a1 && c < a1 + l1) || (c >= a2 && c < a2 + l2);
      start = restart && (dbg_state == MEASURE || valid);
      if (valid) begin
        vcyc = c;
        got_w = width;
        got_t = timeout;
        chk("busy_in_done", busy, 0);
      end
      tick();
      c++;
    end
    start = 1'b0;
    echo_in = 1'b0;
    if (vcyc < 0) begin
      chk("valid_seen", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      chk("valid_cycle", vcyc, exp_vc);
      chk("width", got_w, exp_q.pop_front());
      chk("timeout", got_t, exp_t);
      extra = 0;
      for (int k = 0; k < 10; k++) begin
        if (valid || trig_out || busy) extra++;
        tick();
      end
      chk("quiet_after_done", extra, 0);
      chk("idle_state", int'(dbg_state), int'(IDLE));
      chk("width_held", width, exp_w);
    end
  endtask

  typedef struct {
    int a1;
    int l1;
    int a2;
    int l2;
    bit restart;
    int exp_w;
    bit exp_t;
  } vec_t;

  vec_t tab[8];

  initial begin
    int mw;
    bit mt;
    int mvc;
    int ra;
    int rl;
    int n;

    tab[0] = '{10, 37,   0,  0, 1'b0, 37,       1'b0};
    tab[1] = '{0,  0,    0,  0, 1'b0, 0,        1'b1};
    tab[2] = '{10, 1000, 0,  0, 1'b0, 100,      1'b1};
    tab[3] = '{5,  30,   0,  0, 1'b1, 30,       1'b0};
    tab[4] = '{8,  100,  0,  0, 1'b0, 100,      1'b0};
    tab[5] = '{8,  101,  0,  0, 1'b0, 100,      1'b1};
    tab[6] = '{5,  1,    20, 12, 1'b0, GLITCH_W, 1'b0};
    tab[7] = '{0,  5,    0,  0, 1'b0, 5,        1'b0};

    // Reset state
    reset = 1'b1;
    start = 1'b0;
    echo_in = 1'b0;
    repeat (3) tick();
    chk("rst_trig", trig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_width", width, 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));

    // Start coinciding with reset is dropped
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("start_in_reset_busy", busy, 0);
    chk("start_in_reset_trig", trig_out, 0);
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      model(tab[i].a1, tab[i].l1, tab[i].a2, tab[i].l2, mw, mt, mvc);
      ping(tab[i].a1, tab[i].l1, tab[i].a2, tab[i].l2, tab[i].restart,
           tab[i].exp_w, tab[i].exp_t, mvc);
    end

    // Reset during MEASURE at cnt=20
    ping(3, 25, 0, 0, 1'b0, 25, 1'b0, 3 + 25 + LAT + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (trig_out && n < 50) begin
      n++;
      tick();
    end
    echo_in = 1'b1;
    for (int c = 0; c < LAT + 20; c++) tick();
    chk("pre_reset_state", int'(dbg_state), int'(MEASURE));
    reset = 1'b1;
    tick();
    chk("midrst_trig", trig_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_width", width, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_state", int'(dbg_state), int'(IDLE));
    reset = 1'b0;
    echo_in = 1'b0;
    repeat (10) tick();
    ping(12, 40, 0, 0, 1'b0, 40, 1'b0, 12 + 40 + LAT + 1);

    // Random pings against the model
    for (int i = 0; i < 12; i++) begin
      ra = $urandom_range(0, 60);
      rl = $urandom_range(1, 130);
      model(ra, rl, 0, 0, mw, mt, mvc);
      ping(ra, rl, 0, 0, 1'b0, mw, mt, mvc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
